instr_cycle_sequencer: RTL and testbench

Parametrised instruction-cycle sequencer for the PIC16-class core.
- Generates the Q-phase count and instruction-cycle boundaries.
- Classifies control-flow instructions and drives the instruction-register and PC control strobes.
- Adds over the current decoder: stall, two-cycle FLUSH tracking, SLEEP/wake, a cycle counter, and optional interrupt entry.
- Sits between the instruction register and the PC/stack; ALU and register-file control decode stays in the existing decoder, which consumes q_phase.

---
 rtl/instr_cycle_sequencer_if.sv | 46 ++++
 rtl/instr_cycle_sequencer.sv | 129 ++++++++++++
 tb/tb_instr_cycle_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_cycle_sequencer_if.sv
// Bus between the instruction-cycle sequencer and the surrounding PIC16 core.
// The sequencer takes the master side; the instruction register, datapath and PC/stack take the slave side.
interface instr_cycle_sequencer_if #(
  parameter int Q_PHASES = 4,
  parameter int CNT_W    = 16
);
  localparam int QW = $clog2(Q_PHASES);

  logic [13:0]      instr_current;
  logic             skip_cond;
  logic             stall;
  logic             wake;
  logic             irq_req;
  logic             gie;

  logic [QW-1:0]    q_phase;
  logic             cycle_end;
  logic             second_cycle;
  logic             sleeping;
  logic             instr_rd_en;
  logic             instr_flush;
  logic             pc_incr_en;
  logic             pc_j_en;
  logic             pc_j_and_push_en;
  logic             pc_j_by_pop_en;
  logic             irq_vec_sel;
  logic             gie_clr;
  logic             gie_set;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  instr_current, skip_cond, stall, wake, irq_req, gie,
    output q_phase, cycle_end, second_cycle, sleeping,
           instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
           pc_j_and_push_en, pc_j_by_pop_en, irq_vec_sel, gie_clr, gie_set,
           cycle_count
  );

  modport slave (
    output instr_current, skip_cond, stall, wake, irq_req, gie,
    input  q_phase, cycle_end, second_cycle, sleeping,
           instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
           pc_j_and_push_en, pc_j_by_pop_en, irq_vec_sel, gie_clr, gie_set,
           cycle_count
  );
endinterface

// File: rtl/instr_cycle_sequencer.sv
// Q-phase / instruction-cycle sequencer with FLUSH, SLEEP, stall and cycle counting.
// Optional interrupt entry is enabled by defining SEQ_INTERRUPT_EN.
module instr_cycle_sequencer #(
  parameter int Q_PHASES = 4,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_cycle_sequencer_if.master bus
);
  localparam int QW = $clog2(Q_PHASES);
  localparam logic [QW-1:0] Q_LAST = QW'(Q_PHASES - 1);

  typedef enum logic [1:0] {RUN, FLUSH, SLEEP} state_t;
  typedef enum logic [2:0] {C_PLAIN, C_SKIP, C_GOTO, C_CALL, C_RET, C_RETFIE, C_SLEEP} iclass_t;

  state_t           state, next_state;
  iclass_t          iclass;
  logic [QW-1:0]    q_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             active;
  logic             last_phase;
  logic             eligible;
  logic             irq_take;
  logic             wake_req;

  logic rd_en, flush, incr, jmp, push, pop, vec, clr, set;

`ifdef SEQ_INTERRUPT_EN
  assign irq_take = bus.irq_req & bus.gie;
  assign wake_req = bus.wake | bus.irq_req;
`else
  logic unused_irq;
  assign unused_irq = bus.irq_req ^ bus.gie;
  assign irq_take   = 1'b0;
  assign wake_req   = bus.wake;
`endif

  always_comb begin
    iclass = C_PLAIN;
    casez (bus.instr_current)
      14'b10_1???_????_????: iclass = C_GOTO;
      14'b10_0???_????_????: iclass = C_CALL;
      14'b00_0000_0000_1000: iclass = C_RET;
      14'b00_0000_0000_1001: iclass = C_RETFIE;
      14'b11_01??_????_????: iclass = C_RET;
      14'b00_0000_0110_0011: iclass = C_SLEEP;
      14'b00_1011_????_????,
      14'b00_1111_????_????,
      14'b01_1???_????_????: iclass = C_SKIP;
      default:               iclass = C_PLAIN;
    endcase
  end

  assign active     = !rst && !bus.stall;
  assign last_phase = (q_reg == Q_LAST);
  assign eligible   = (iclass == C_PLAIN) || (iclass == C_SKIP && !bus.skip_cond);

  // Strobes only ever fire on the last phase of a non-stalled RUN or FLUSH cycle.
  always_comb begin
    next_state = state;
    rd_en = 1'b0; flush = 1'b0; incr = 1'b0; jmp = 1'b0; push = 1'b0;
    pop   = 1'b0; vec   = 1'b0; clr  = 1'b0; set = 1'b0;
    if (active) begin
      case (state)
        RUN: begin
          if (last_phase) begin
            if (eligible) begin
              if (irq_take) begin
                flush = 1'b1; push = 1'b1; vec = 1'b1; clr = 1'b1;
                next_state = FLUSH;
              end else begin
                rd_en = 1'b1; incr = 1'b1;
              end
            end else begin
              case (iclass)
                C_SKIP:   begin flush = 1'b1; incr = 1'b1; next_state = FLUSH; end
                C_GOTO:   begin flush = 1'b1; jmp  = 1'b1; next_state = FLUSH; end
                C_CALL:   begin flush = 1'b1; push = 1'b1; next_state = FLUSH; end
                C_RET:    begin flush = 1'b1; pop  = 1'b1; next_state = FLUSH; end
                C_RETFIE: begin flush = 1'b1; pop  = 1'b1; set = 1'b1; next_state = FLUSH; end
                C_SLEEP:  begin rd_en = 1'b1; incr = 1'b1; next_state = SLEEP; end
                default:  begin rd_en = 1'b1; incr = 1'b1; end
              endcase
            end
          end
        end
        FLUSH: begin
          if (last_phase) begin
            rd_en = 1'b1; incr = 1'b1;
            next_state = RUN;
          end
        end
        SLEEP: begin
          if (wake_req) next_state = RUN;
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      q_reg   <= '0;
      cnt_reg <= '0;
    end else if (!bus.stall) begin
      state <= next_state;
      if (state == SLEEP || next_state == SLEEP || last_phase) q_reg <= '0;
      else                                                     q_reg <= q_reg + 1'b1;
      if (bus.cycle_end) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.q_phase          = q_reg;
  assign bus.cycle_end        = active && last_phase && (state != SLEEP);
  assign bus.second_cycle     = (state == FLUSH);
  assign bus.sleeping         = (state == SLEEP);
  assign bus.instr_rd_en      = rd_en;
  assign bus.instr_flush      = flush;
  assign bus.pc_incr_en       = incr;
  assign bus.pc_j_en          = jmp;
  assign bus.pc_j_and_push_en = push;
  assign bus.pc_j_by_pop_en   = pop;
  assign bus.irq_vec_sel      = vec;
  assign bus.gie_clr          = clr;
  assign bus.gie_set          = set;
  assign bus.cycle_count      = cnt_reg;
endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Directed self-checking bench for instr_cycle_sequencer (Q_PHASES=4, CNT_W=16).
// Interrupt scenarios follow SEQ_INTERRUPT_EN when it is defined for the build.
module tb_instr_cycle_sequencer;
  bit   clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  localparam logic [8:0] S_RD = 9'h100, S_FL = 9'h080, S_INC = 9'h040, S_J = 9'h020,
                         S_PUSH = 9'h010, S_POP = 9'h008, S_VEC = 9'h004, S_CLR = 9'h002,
                         S_SET = 9'h001;

  instr_cycle_sequencer_if #(.Q_PHASES(4), .CNT_W(16)) bus ();

  instr_cycle_sequencer #(.Q_PHASES(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] strobes();
    return {bus.instr_rd_en, bus.instr_flush, bus.pc_incr_en, bus.pc_j_en,
            bus.pc_j_and_push_en, bus.pc_j_by_pop_en, bus.irq_vec_sel,
            bus.gie_clr, bus.gie_set};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_current = 14'h0000;
    bus.skip_cond = 1'b0; bus.stall = 1'b0; bus.wake = 1'b0;
    bus.irq_req = 1'b0; bus.gie = 1'b0;
    step(); step(); #1;
    checks++; if (bus.q_phase !== 2'd0) begin errors++; $display("[TB] FAIL reset_q got %0d want 0", bus.q_phase); end
    checks++; if (bus.cycle_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", bus.cycle_count); end
    checks++; if (strobes() !== 9'h000) begin errors++; $display("[TB] FAIL reset_strobes got %h want 000", strobes()); end
    checks++; if (bus.sleeping !== 1'b0 || bus.second_cycle !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_state got sleeping=%b second=%b want 0 0", bus.sleeping, bus.second_cycle);
    end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_nop_stream();
    logic [8:0] exp_s;
    bus.instr_current = 14'h0000;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_s = (i % 4 == 3) ? (S_RD | S_INC) : 9'h000;
      checks++; if (bus.q_phase !== 2'(i % 4)) begin errors++; $display("[TB] FAIL nop_q[%0d] got %0d want %0d", i, bus.q_phase, i % 4); end
      checks++; if (strobes() !== exp_s) begin errors++; $display("[TB] FAIL nop_strobes[%0d] got %h want %h", i, strobes(), exp_s); end
      checks++; if (bus.cycle_end !== (i % 4 == 3)) begin errors++; $display("[TB] FAIL nop_cycle_end[%0d] got %b", i, bus.cycle_end); end
      step();
    end
    exp_cnt += 3;
    #1;
    checks++; if (bus.cycle_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL nop_count got %0d want %0d", bus.cycle_count, exp_cnt); end
  endtask

  task automatic test_control_flow();
    logic [13:0] ins [6];
    logic [8:0]  exp_end [6];
    logic [8:0]  exp_s;
    ins     = '{14'h2805, 14'h2000, 14'h0008, 14'h0009, 14'h3455, 14'h0B10};
    exp_end = '{S_FL | S_J, S_FL | S_PUSH, S_FL | S_POP, S_FL | S_POP | S_SET, S_FL | S_POP, S_FL | S_INC};
    bus.skip_cond = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.instr_current = ins[k];
      for (int i = 0; i < 8; i++) begin
        // During the flush cycle a goto sits in the IR; it must be ignored.
        if (i == 4) bus.instr_current = 14'h2805;
        #1;
        exp_s = (i == 3) ? exp_end[k] : (i == 7) ? (S_RD | S_INC) : 9'h000;
        checks++; if (strobes() !== exp_s) begin errors++; $display("[TB] FAIL cf_strobes[%0d][%0d] got %h want %h", k, i, strobes(), exp_s); end
        checks++; if (bus.second_cycle !== (i >= 4)) begin errors++; $display("[TB] FAIL cf_second[%0d][%0d] got %b want %b", k, i, bus.second_cycle, i >= 4); end
        step();
      end
      exp_cnt += 2;
      checks++; if (bus.cycle_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL cf_count[%0d] got %0d want %0d", k, bus.cycle_count, exp_cnt); end
    end
    bus.skip_cond = 1'b0;
    bus.instr_current = 14'h0000;
  endtask

  task automatic test_skip_not_taken();
    logic [13:0] ins [4];
    logic [8:0]  exp_s;
    ins = '{14'h0B10, 14'h0F22, 14'h1803, 14'h1C03};
    bus.skip_cond = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.instr_current = ins[k];
      for (int i = 0; i < 4; i++) begin
        #1;
        exp_s = (i == 3) ? (S_RD | S_INC) : 9'h000;
        checks++; if (strobes() !== exp_s) begin errors++; $display("[TB] FAIL skipnt_strobes[%0d][%0d] got %h want %h", k, i, strobes(), exp_s); end
        checks++; if (bus.second_cycle !== 1'b0) begin errors++; $display("[TB] FAIL skipnt_second[%0d][%0d] got 1 want 0", k, i); end
        step();
      end
    end
    exp_cnt += 4;
    bus.instr_current = 14'h0000;
    checks++; if (bus.cycle_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL skipnt_count got %0d want %0d", bus.cycle_count, exp_cnt); end
  endtask

  task automatic test_stall();
    bus.instr_current = 14'h0000;
    step(); step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.q_phase !== 2'd2) begin errors++; $display("[TB] FAIL stall_q[%0d] got %0d want 2", i, bus.q_phase); end
      checks++; if (strobes() !== 9'h000 || bus.cycle_end !== 1'b0) begin errors++; $display("[TB] FAIL stall_strobes[%0d] got %h end=%b want 000 0", i, strobes(), bus.cycle_end); end
      step();
    end
    bus.stall = 1'b0;
    #1;
    checks++; if (bus.q_phase !== 2'd2) begin errors++; $display("[TB] FAIL stall_release_q got %0d want 2", bus.q_phase); end
    step();
    checks++; if (strobes() !== (S_RD | S_INC) || bus.cycle_end !== 1'b1) begin errors++; $display("[TB] FAIL stall_end got %h end=%b want 140 1", strobes(), bus.cycle_end); end
    bus.stall = 1'b1;
    #1;
    checks++; if (strobes() !== 9'h000 || bus.cycle_end !== 1'b0) begin errors++; $display("[TB] FAIL stall_last got %h end=%b want 000 0", strobes(), bus.cycle_end); end
    step();
    checks++; if (bus.q_phase !== 2'd3 || bus.cycle_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL stall_hold got q=%0d cnt=%0d want 3 %0d", bus.q_phase, bus.cycle_count, exp_cnt); end
    bus.stall = 1'b0;
    #1;
    checks++; if (strobes() !== (S_RD | S_INC)) begin errors++; $display("[TB] FAIL stall_resume got %h want 140", strobes()); end
    step();
    exp_cnt += 1;
    checks++; if (bus.q_phase !== 2'd0 || bus.cycle_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL stall_after got q=%0d cnt=%0d want 0 %0d", bus.q_phase, bus.cycle_count, exp_cnt); end
  endtask

  task automatic test_sleep();
    logic [8:0] exp_s;
    bus.instr_current = 14'h0063;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_s = (i == 3) ? (S_RD | S_INC) : 9'h000;
      checks++; if (strobes() !== exp_s) begin errors++; $display("[TB] FAIL sleep_prefetch[%0d] got %h want %h", i, strobes(), exp_s); end
      step();
    end
    exp_cnt += 1;
    bus.instr_current = 14'h0000;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (bus.sleeping !== 1'b1 || bus.q_phase !== 2'd0 || strobes() !== 9'h000) begin
        errors++; $display("[TB] FAIL sleep_hold[%0d] got sleeping=%b q=%0d strobes=%h want 1 0 000", i, bus.sleeping, bus.q_phase, strobes());
      end
      step();
    end
    checks++; if (bus.cycle_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL sleep_count got %0d want %0d", bus.cycle_count, exp_cnt); end
    bus.stall = 1'b1; bus.wake = 1'b1;
    step();
    checks++; if (bus.sleeping !== 1'b1) begin errors++; $display("[TB] FAIL sleep_stalled_wake got sleeping=0 want 1"); end
    bus.stall = 1'b0;
    step();
    bus.wake = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_s = (i == 3) ? (S_RD | S_INC) : 9'h000;
      checks++; if (bus.sleeping !== 1'b0 || bus.q_phase !== 2'(i)) begin errors++; $display("[TB] FAIL wake_q[%0d] got sleeping=%b q=%0d want 0 %0d", i, bus.sleeping, bus.q_phase, i); end
      checks++; if (strobes() !== exp_s) begin errors++; $display("[TB] FAIL wake_strobes[%0d] got %h want %h", i, strobes(), exp_s); end
      step();
    end
    exp_cnt += 1;
    checks++; if (bus.cycle_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL wake_count got %0d want %0d", bus.cycle_count, exp_cnt); end
  endtask

  task automatic test_irq();
    logic [8:0] exp_s;
    bus.instr_current = 14'h0000;
    bus.irq_req = 1'b1; bus.gie = 1'b1;
`ifdef SEQ_INTERRUPT_EN
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_s = (i == 3) ? (S_FL | S_PUSH | S_VEC | S_CLR) : (i == 7) ? (S_RD | S_INC) : 9'h000;
      checks++; if (strobes() !== exp_s) begin errors++; $display("[TB] FAIL irq_plain[%0d] got %h want %h", i, strobes(), exp_s); end
      step();
    end
    bus.instr_current = 14'h2805;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) bus.instr_current = 14'h0000;
      if (i == 12) bus.irq_req = 1'b0;
      #1;
      exp_s = (i == 3)  ? (S_FL | S_J) :
              (i == 7)  ? (S_RD | S_INC) :
              (i == 11) ? (S_FL | S_PUSH | S_VEC | S_CLR) :
              (i == 15) ? (S_RD | S_INC) : 9'h000;
      checks++; if (strobes() !== exp_s) begin errors++; $display("[TB] FAIL irq_deferred[%0d] got %h want %h", i, strobes(), exp_s); end
      step();
    end
    exp_cnt += 6;
    bus.gie = 1'b0;
    bus.instr_current = 14'h0063;
    step(); step(); step(); step();
    bus.instr_current = 14'h0000;
    step(); step();
    checks++; if (bus.sleeping !== 1'b1) begin errors++; $display("[TB] FAIL irq_sleep_enter got 0 want 1"); end
    bus.irq_req = 1'b1;
    step();
    bus.irq_req = 1'b0;
    checks++; if (bus.sleeping !== 1'b0 || bus.q_phase !== 2'd0) begin errors++; $display("[TB] FAIL irq_wake got sleeping=%b q=%0d want 0 0", bus.sleeping, bus.q_phase); end
    exp_cnt += 1;
`else
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_s = (i == 3) ? (S_RD | S_INC) : 9'h000;
      checks++; if (strobes() !== exp_s) begin errors++; $display("[TB] FAIL irq_ignored[%0d] got %h want %h", i, strobes(), exp_s); end
      step();
    end
    bus.instr_current = 14'h0063;
    step(); step(); step(); step();
    bus.instr_current = 14'h0000;
    step(); step(); step();
    checks++; if (bus.sleeping !== 1'b1) begin errors++; $display("[TB] FAIL irq_no_wake got sleeping=0 want 1"); end
    bus.wake = 1'b1;
    step();
    bus.wake = 1'b0; bus.irq_req = 1'b0; bus.gie = 1'b0;
    checks++; if (bus.sleeping !== 1'b0 || bus.q_phase !== 2'd0) begin errors++; $display("[TB] FAIL irq_wake got sleeping=%b q=%0d want 0 0", bus.sleeping, bus.q_phase); end
    exp_cnt += 2;
`endif
    checks++; if (bus.cycle_count !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL irq_count got %0d want %0d", bus.cycle_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    bus.instr_current = 14'h2805;
    step(); step(); step();
    rst = 1'b1;
    #1;
    checks++; if (strobes() !== 9'h000 || bus.cycle_end !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_strobes got %h end=%b want 000 0", strobes(), bus.cycle_end); end
    step();
    checks++; if (bus.q_phase !== 2'd0 || bus.cycle_count !== 16'd0 || bus.second_cycle !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_state got q=%0d cnt=%0d second=%b want 0 0 0", bus.q_phase, bus.cycle_count, bus.second_cycle);
    end
    rst = 1'b0;
    exp_cnt = 0;
    bus.instr_current = 14'h0000;
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_control_flow();
    test_skip_not_taken();
    test_stall();
    test_sleep();
    test_irq();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
